// File: rtl/ptp_parser_gen2_if.sv
// MAC-side monitor tap bundle for ptp_parser_gen2: byte lanes, lane keeps, beat valid, frame last.
// There is no ready signal because the tap cannot be back-pressured.
interface ptp_parser_gen2_if #(
   parameter int DATA_W = 64
);
   logic [DATA_W-1:0]   s_data;
   logic [DATA_W/8-1:0] s_keep;
   logic                s_valid;
   logic                s_last;

   modport master (output s_data, s_keep, s_valid, s_last);
   modport slave  (input  s_data, s_keep, s_valid, s_last);
endinterface

// File: rtl/ptp_parser_gen2.sv
// PTP classifier: ping-pong header capture plus a one-header-per-cycle walk (Eth/VLAN/IPv4/IPv6/UDP/PTP).
// Define PTP_PARSER_IPV6_EN to include the IPv6 walk state; otherwise ethertype 86DD is reported as non-PTP.
module ptp_parser_gen2 #(
   parameter int DATA_W    = 64,
   parameter int HDR_BYTES = 128,
   parameter int MAX_VLAN  = 2
) (
   input  logic                clk,
   input  logic                rst,
   ptp_parser_gen2_if.slave    s,
   input  logic [15:0]         msgid_mask,
   output logic                res_valid,
   output logic                res_ptp,
   output logic                res_l4,
   output logic                res_event,
   output logic                res_trunc,
   output logic [3:0]          res_msgtype,
   output logic [7:0]          res_domain,
   output logic [15:0]         res_seqid,
   output logic [11:0]         res_cksum,
   output logic [7:0]          res_ptp_off,
   output logic [15:0]         abort_cnt
);
   localparam int         BYTES = DATA_W / 8;
   localparam int         IW    = $clog2(HDR_BYTES);
   localparam logic [9:0] HDR_L = 10'(HDR_BYTES);
   localparam logic [1:0] MAXV  = 2'(MAX_VLAN);

   typedef enum logic [2:0] {
      S_IDLE, S_TYPE, S_IP4,
`ifdef PTP_PARSER_IPV6_EN
      S_IP6,
`endif
      S_UDP, S_PTP, S_EMIT
   } state_t;

   function automatic logic [IW-1:0] ix(input logic [9:0] k);
      return k[IW-1:0];
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [7:0] hbuf [2][HDR_BYTES];
   logic       in_pkt, wsel, fsel, first, trig;
   logic [9:0] cnt, cnt_base, cnt_sum, cnt_new, kcnt, lenf;
   logic [9:0] len [2];

   // capture: byte count of the current frame and the once-per-frame trigger
   always_comb begin
      kcnt = '0;
      for (int i = 0; i < BYTES; i++) kcnt = kcnt + 10'(s.s_keep[i]);
      first    = s.s_valid & ~in_pkt;
      cnt_base = first ? 10'd0 : cnt;
      cnt_sum  = cnt_base + kcnt;
      cnt_new  = (cnt_sum > HDR_L) ? HDR_L : cnt_sum;
      trig     = s.s_valid && (cnt_base < HDR_L) && ((cnt_new == HDR_L) || s.s_last);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_pkt <= 1'b0;
         wsel   <= 1'b0;
         fsel   <= 1'b0;
         cnt    <= '0;
         len[0] <= '0;
         len[1] <= '0;
      end else if (s.s_valid) begin
         in_pkt <= ~s.s_last;
         cnt    <= cnt_new;
         if (trig) begin
            len[wsel] <= cnt_new;
            fsel      <= wsel;
            wsel      <= ~wsel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (s.s_valid) begin
         for (int i = 0; i < BYTES; i++) begin
            if (s.s_keep[BYTES-1-i] && ((cnt_base + 10'(i)) < HDR_L))
               hbuf[wsel][ix(cnt_base + 10'(i))] <= s.s_data[DATA_W-1-8*i -: 8];
         end
      end
   end

   // walk: one protocol header per cycle over the frozen buffer fsel
   state_t      state, nxt;
   logic [9:0]  cur, cur_nxt;
   logic [1:0]  tags, tags_nxt;
   logic        w_l4, l4_nxt, ptp_ok, trunc, abort;
   logic [15:0] et, p_seqid;
   logic [7:0]  b0, p_domain;
   logic [3:0]  p_msgtype;
   logic [11:0] p_cksum;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt       = state;
      cur_nxt   = cur;
      tags_nxt  = tags;
      l4_nxt    = w_l4;
      ptp_ok    = 1'b0;
      trunc     = 1'b0;
      abort     = 1'b0;
      et        = '0;
      b0        = '0;
      p_msgtype = '0;
      p_domain  = '0;
      p_seqid   = '0;
      p_cksum   = '0;
      lenf      = len[fsel];
      case (state)
         S_IDLE: ;
         S_TYPE: begin
            if (cur + 10'd1 >= lenf) begin
               trunc = 1'b1;
               nxt   = S_EMIT;
            end else begin
               et = {hbuf[fsel][ix(cur)], hbuf[fsel][ix(cur + 10'd1)]};
               if (et == 16'h8100 || et == 16'h88A8 || et == 16'h9100) begin
                  if (tags < MAXV) begin
                     tags_nxt = tags + 2'd1;
                     cur_nxt  = cur + 10'd4;
                  end else nxt = S_EMIT;
               end else if (et == 16'h88F7) begin
                  cur_nxt = cur + 10'd2;
                  nxt     = S_PTP;
               end else if (et == 16'h0800) begin
                  cur_nxt = cur + 10'd2;
                  nxt     = S_IP4;
`ifdef PTP_PARSER_IPV6_EN
               end else if (et == 16'h86DD) begin
                  cur_nxt = cur + 10'd2;
                  nxt     = S_IP6;
`endif
               end else nxt = S_EMIT;
            end
         end
         S_IP4: begin
            b0 = hbuf[fsel][ix(cur)];
            if (cur + 10'd9 >= lenf) begin
               trunc = 1'b1;
               nxt   = S_EMIT;
            end else if (b0[7:4] == 4'd4 && b0[3:0] >= 4'd5 &&
                         hbuf[fsel][ix(cur + 10'd9)] == 8'h11) begin
               cur_nxt = cur + {4'd0, b0[3:0], 2'b00};
               nxt     = S_UDP;
            end else nxt = S_EMIT;
         end
`ifdef PTP_PARSER_IPV6_EN
         S_IP6: begin
            if (cur + 10'd6 >= lenf) begin
               trunc = 1'b1;
               nxt   = S_EMIT;
            end else if (hbuf[fsel][ix(cur + 10'd6)] == 8'h11) begin
               cur_nxt = cur + 10'd40;
               nxt     = S_UDP;
            end else nxt = S_EMIT;
         end
`endif
         S_UDP: begin
            et = {hbuf[fsel][ix(cur + 10'd2)], hbuf[fsel][ix(cur + 10'd3)]};
            if (cur + 10'd3 >= lenf) begin
               trunc = 1'b1;
               nxt   = S_EMIT;
            end else if (et == 16'h013F || et == 16'h0140) begin
               l4_nxt  = 1'b1;
               cur_nxt = cur + 10'd8;
               nxt     = S_PTP;
            end else nxt = S_EMIT;
         end
         S_PTP: begin
            nxt = S_EMIT;
            if (cur + 10'd33 >= lenf) trunc = 1'b1;
            else begin
               ptp_ok    = 1'b1;
               b0        = hbuf[fsel][ix(cur)];
               p_msgtype = b0[3:0];
               p_domain  = hbuf[fsel][ix(cur + 10'd4)];
               p_seqid   = {hbuf[fsel][ix(cur + 10'd30)], hbuf[fsel][ix(cur + 10'd31)]};
               for (int j = 0; j < 10; j++)
                  p_cksum = p_cksum + {4'd0, hbuf[fsel][ix(cur + 10'(20 + j))]};
            end
         end
         S_EMIT: nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      // a new frame always wins: an unfinished walk is dropped and counted
      if (trig) begin
         abort    = (state != S_IDLE) && (state != S_EMIT);
         nxt      = S_TYPE;
         cur_nxt  = 10'd12;
         tags_nxt = '0;
         l4_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur         <= '0;
         tags        <= '0;
         w_l4        <= 1'b0;
         res_valid   <= 1'b0;
         res_ptp     <= 1'b0;
         res_l4      <= 1'b0;
         res_event   <= 1'b0;
         res_trunc   <= 1'b0;
         res_msgtype <= '0;
         res_domain  <= '0;
         res_seqid   <= '0;
         res_cksum   <= '0;
         res_ptp_off <= '0;
         abort_cnt   <= '0;
      end else begin
         cur       <= cur_nxt;
         tags      <= tags_nxt;
         w_l4      <= l4_nxt;
         res_valid <= (nxt == S_EMIT);
         if (nxt == S_EMIT) begin
            res_ptp     <= ptp_ok;
            res_trunc   <= trunc;
            res_l4      <= l4_nxt;
            res_event   <= ptp_ok & msgid_mask[p_msgtype];
            res_msgtype <= p_msgtype;
            res_domain  <= p_domain;
            res_seqid   <= p_seqid;
            res_cksum   <= p_cksum;
            res_ptp_off <= ptp_ok ? cur[7:0] : 8'd0;
         end
         if (abort) abort_cnt <= sat_inc(abort_cnt);
      end
   end
endmodule

// File: tb/tb_ptp_parser_gen2.sv
// Directed bench for ptp_parser_gen2: a table of frame recipes with expected results, plus
// reset-mid-frame and back-to-back abort sequences.
module tb_ptp_parser_gen2;
   localparam int DW = 64, BY = DW / 8, HDR = 128;

   logic clk = 1'b0, rst = 1'b1;
   logic [15:0] msgid_mask = 16'h000F;
   logic res_valid, res_ptp, res_l4, res_event, res_trunc;
   logic [3:0] res_msgtype;
   logic [7:0] res_domain, res_ptp_off;
   logic [15:0] res_seqid, abort_cnt;
   logic [11:0] res_cksum;

   ptp_parser_gen2_if #(.DATA_W(DW)) bus();

   ptp_parser_gen2 #(.DATA_W(DW), .HDR_BYTES(HDR), .MAX_VLAN(2)) dut (
      .clk(clk), .rst(rst), .s(bus), .msgid_mask(msgid_mask),
      .res_valid(res_valid), .res_ptp(res_ptp), .res_l4(res_l4), .res_event(res_event),
      .res_trunc(res_trunc), .res_msgtype(res_msgtype), .res_domain(res_domain),
      .res_seqid(res_seqid), .res_cksum(res_cksum), .res_ptp_off(res_ptp_off),
      .abort_cnt(abort_cnt));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0, nbad = 0;
   int rv_cnt = 0, rv_cyc = 0;
   logic c_ptp, c_l4, c_evt, c_trunc;
   logic [3:0] c_mt;
   logic [7:0] c_dom, c_off;
   logic [15:0] c_seq;
   logic [11:0] c_ck;

   always @(negedge clk) begin
      if (res_valid) begin
         if (rv_cnt == 0) begin
            rv_cyc = cyc; c_ptp = res_ptp; c_l4 = res_l4; c_evt = res_event; c_trunc = res_trunc;
            c_mt = res_msgtype; c_dom = res_domain; c_off = res_ptp_off; c_seq = res_seqid;
            c_ck = res_cksum;
         end
         rv_cnt++;
      end
   end

   typedef struct {
      int ntag; logic [15:0] t0, t1, t2; logic [15:0] etype; int l3; logic [15:0] dport;
      logic [3:0] mt; logic [7:0] dom; logic [15:0] seq; bit srcff; int flen; logic [15:0] mask;
      int lat; bit ptp, l4, evt, trunc; logic [7:0] off; logic [11:0] ck;
   } vec_t;

   vec_t vt [11];
   logic [7:0] fr [256];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic build(input vec_t v, output int n);
      int p;
      logic [15:0] tp;
      for (int i = 0; i < 256; i++) fr[i] = 8'h00;
      for (int i = 0; i < 12; i++) fr[i] = 8'hA0 + 8'(i);
      p = 12;
      for (int t = 0; t < v.ntag; t++) begin
         tp = (t == 0) ? v.t0 : (t == 1) ? v.t1 : v.t2;
         fr[p] = tp[15:8]; fr[p+1] = tp[7:0]; fr[p+3] = 8'(t + 1);
         p += 4;
      end
      fr[p] = v.etype[15:8]; fr[p+1] = v.etype[7:0]; p += 2;
      if (v.l3 == 4) begin fr[p] = 8'h45; fr[p+9] = 8'h11; p += 20; end
      else if (v.l3 == 6) begin fr[p] = 8'h60; fr[p+6] = 8'h11; p += 40; end
      if (v.l3 != 0) begin
         fr[p] = 8'h01; fr[p+1] = 8'h3F; fr[p+2] = v.dport[15:8]; fr[p+3] = v.dport[7:0];
         p += 8;
      end
      fr[p] = {4'h0, v.mt}; fr[p+1] = 8'h02; fr[p+4] = v.dom;
      for (int j = 0; j < 10; j++) fr[p+20+j] = v.srcff ? 8'hFF : 8'(j + 1);
      fr[p+30] = v.seq[15:8]; fr[p+31] = v.seq[7:0];
      n = (v.flen != 0) ? v.flen : p + 44;
   endtask

   task automatic send_frame(input int n, output int te);
      int nb, tb;
      logic [DW-1:0] d;
      logic [BY-1:0] k;
      nb = (n + BY - 1) / BY;
      tb = (((n < HDR) ? n : HDR) - 1) / BY;
      te = 0;
      for (int b = 0; b < nb; b++) begin
         d = '0; k = '0;
         for (int i = 0; i < BY; i++) begin
            if (b * BY + i < n) begin
               d[DW-1-8*i -: 8] = fr[b*BY+i];
               k[BY-1-i] = 1'b1;
            end
         end
         bus.s_data = d; bus.s_keep = k; bus.s_valid = 1'b1; bus.s_last = (b == nb - 1);
         @(posedge clk); #1;
         if (b == tb) te = cyc;
      end
      bus.s_valid = 1'b0; bus.s_last = 1'b0;
   endtask

   task automatic wait_result();
      for (int w = 0; w < 30 && rv_cnt == 0; w++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int n, te;
      msgid_mask = v.mask;
      build(v, n);
      rv_cnt = 0;
      send_frame(n, te);
      wait_result();
      chk({nm, ".pulses"}, rv_cnt, 1);
      if (rv_cnt > 0) begin
         chk({nm, ".lat"}, rv_cyc - te + 1, v.lat);
         chk({nm, ".ptp"}, c_ptp, v.ptp);
         chk({nm, ".l4"}, c_l4, v.l4);
         chk({nm, ".event"}, c_evt, v.evt);
         chk({nm, ".trunc"}, c_trunc, v.trunc);
         if (v.ptp) begin
            chk({nm, ".msgtype"}, c_mt, v.mt);
            chk({nm, ".domain"}, c_dom, v.dom);
            chk({nm, ".seqid"}, c_seq, v.seq);
            chk({nm, ".cksum"}, c_ck, v.ck);
            chk({nm, ".ptp_off"}, c_off, v.off);
            chk({nm, ".seqid_hold"}, res_seqid, v.seq);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, te;
      bus.s_data = '0; bus.s_keep = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;

      vt[0]  = '{0, 16'h0, 16'h0, 16'h0, 16'h88F7, 0, 16'h0, 4'd0, 8'h18, 16'h1234, 1'b0, 0, 16'h000F,
                 3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd14, 12'h037};
      vt[1]  = '{2, 16'h88A8, 16'h8100, 16'h0, 16'h0800, 4, 16'h013F, 4'd1, 8'h05, 16'h0042, 1'b0, 0,
                 16'h000F, 7, 1'b1, 1'b1, 1'b1, 1'b0, 8'd50, 12'h037};
      vt[2]  = '{3, 16'h8100, 16'h8100, 16'h8100, 16'h88F7, 0, 16'h0, 4'd0, 8'h00, 16'h0000, 1'b0, 0,
                 16'h000F, 4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h000};
      vt[3]  = '{0, 16'h0, 16'h0, 16'h0, 16'h88F7, 0, 16'h0, 4'd0, 8'h18, 16'h1234, 1'b0, 41, 16'h000F,
                 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 12'h000};
      vt[4]  = '{0, 16'h0, 16'h0, 16'h0, 16'h88F7, 0, 16'h0, 4'd8, 8'h00, 16'h0007, 1'b1, 0, 16'h000F,
                 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd14, 12'h9F6};
`ifdef PTP_PARSER_IPV6_EN
      vt[5]  = '{0, 16'h0, 16'h0, 16'h0, 16'h86DD, 6, 16'h0140, 4'd3, 8'h2A, 16'hBEEF, 1'b0, 0,
                 16'h000F, 5, 1'b1, 1'b1, 1'b1, 1'b0, 8'd62, 12'h037};
`else
      vt[5]  = '{0, 16'h0, 16'h0, 16'h0, 16'h86DD, 6, 16'h0140, 4'd3, 8'h2A, 16'hBEEF, 1'b0, 0,
                 16'h000F, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h000};
`endif
      vt[6]  = '{0, 16'h0, 16'h0, 16'h0, 16'h0800, 4, 16'h0050, 4'd0, 8'h00, 16'h0000, 1'b0, 0,
                 16'h000F, 4, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h000};
      vt[7]  = '{0, 16'h0, 16'h0, 16'h0, 16'h0806, 0, 16'h0, 4'd0, 8'h00, 16'h0000, 1'b0, 0, 16'h000F,
                 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'h000};
      vt[8]  = '{0, 16'h0, 16'h0, 16'h0, 16'h88F7, 0, 16'h0, 4'd2, 8'h7F, 16'hA5A5, 1'b0, 200, 16'h0004,
                 3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd14, 12'h037};
      vt[9]  = '{0, 16'h0, 16'h0, 16'h0, 16'h88F7, 0, 16'h0, 4'd0, 8'h11, 16'h0001, 1'b0, 0, 16'hFFFE,
                 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd14, 12'h037};
      vt[10] = '{1, 16'h9100, 16'h0, 16'h0, 16'h88F7, 0, 16'h0, 4'd1, 8'h22, 16'h3333, 1'b0, 0, 16'h0002,
                 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'd18, 12'h037};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.res_valid", res_valid, 0);
      chk("rst.res_ptp", res_ptp, 0);
      chk("rst.res_event", res_event, 0);
      chk("rst.res_trunc", res_trunc, 0);
      chk("rst.res_seqid", res_seqid, 0);
      chk("rst.res_ptp_off", res_ptp_off, 0);
      chk("rst.abort_cnt", abort_cnt, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_vec(vt[i], $sformatf("v%0d", i));

      // reset in the middle of a frame: the tail arrives as a frame of its own
      build(vt[0], n);
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < BY; i++) bus.s_data[DW-1-8*i -: 8] = fr[b*BY+i];
         bus.s_keep = '1; bus.s_valid = 1'b1; bus.s_last = 1'b0;
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rstmid.abort_cnt", abort_cnt, 0);
      chk("rstmid.res_valid", res_valid, 0);
      for (int i = 0; i < 240; i++) fr[i] = fr[i+16];
      rv_cnt = 0;
      send_frame(n - 16, te);
      wait_result();
      chk("rstmid.pulses", rv_cnt, 1);
      chk("rstmid.ptp", c_ptp, 0);
      chk("rstmid.trunc", c_trunc, 0);
      run_vec(vt[0], "after_rst");

      // three short frames back to back: the first two walks are cut off by the next trigger
      for (int i = 0; i < 256; i++) fr[i] = 8'h00;
      fr[12] = 8'h81; fr[16] = 8'h81; fr[20] = 8'h08; fr[22] = 8'h45; fr[31] = 8'h11;
      rv_cnt = 0;
      send_frame(32, te);
      send_frame(32, te);
      send_frame(32, te);
      wait_result();
      chk("abort.pulses", rv_cnt, 1);
      chk("abort.abort_cnt", abort_cnt, 2);
      chk("abort.lat", rv_cyc - te + 1, 6);
      chk("abort.trunc", c_trunc, 1);
      chk("abort.ptp", c_ptp, 0);
      chk("abort.event", c_evt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
